ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 26 ++
 rtl/ifetch_fifo.sv | 90 +++++++++
 rtl/ifetch.sv | 160 ++++++++++++++++
 tb/tb_ifetch.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg
//   Shared constants and types for the instruction fetch stage.
//   XLEN          : architectural word width
//   IFETCH_DEPTH  : default queue depth / outstanding-request credit limit
//   NOP_INSN      : canonical RISC-V NOP (addi x0, x0, 0)
//   word_t        : one XLEN word
//   inst_entry_t  : {data, addr} entry held in the instruction queue
//   cnt_width()   : width of a counter that must hold 0..depth inclusive
package ifetch_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned IFETCH_DEPTH = 2;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t data;
    word_t addr;
  } inst_entry_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo
//   Small synchronous FIFO used for both the in-flight address FIFO and the
//   decoded-side instruction queue.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : synchronous clear (redirect); wins over push/pop
//   push, push_data : write one entry
//   pop             : drop the head entry
//   head_data       : current head entry (valid when !empty)
//   count           : number of stored entries, 0..DEPTH
//   empty, full     : occupancy flags
module ifetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full && !pop && !clr)
  );

endmodule

// File: rtl/ifetch.sv
// ifetch
//   Instruction fetch stage with credit-based flow control. Requests are
//   issued straight from fetch_pc; every accepted address is remembered in an
//   in-flight FIFO and paired with its in-order response before entering a
//   registered instruction queue toward decode. A flush empties all local
//   state and arms a drop counter that swallows responses still owed by
//   memory for the abandoned requests.
//   Ports:
//     clk, rst_n                     : clock, asynchronous active-low reset
//     fetch_pc                       : address presented by the pc stage
//     flush                          : redirect pulse, kills all fetch state
//     fetch_advance                  : request accepted this cycle (pc enable)
//     imem_req_valid/ready/addr      : instruction memory request
//     imem_rsp_valid/data            : in-order memory response, no backpressure
//     inst_valid/ready               : decode handshake
//     inst_data, inst_pc             : head instruction and its address
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH          = IFETCH_DEPTH,
  parameter logic [31:0] RST_PC_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        fetch_advance,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned CW = cnt_width(DEPTH);
  // Headroom so the three-way credit sum can never wrap.
  localparam int unsigned SW = CW + 2;

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] queue_count, addr_count;
  logic [SW-1:0] credit_used;
  logic [SW-1:0] pending;

  logic          accept;
  logic          rsp_drop, rsp_keep;
  logic          inst_pop;
  logic          queue_empty, queue_full;
  logic          addr_empty, addr_full;

  word_t         addr_head;
  inst_entry_t   queue_head;
  inst_entry_t   queue_push_entry;

  // Credit covers everything that will still land in the queue or must be
  // swallowed: dropped responses, live requests and queued instructions.
  always_comb begin
    credit_used    = SW'(drop_cnt_q) + SW'(outstanding_q) + SW'(queue_count);
    imem_req_valid = !flush && (credit_used < SW'(DEPTH));
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;
    fetch_advance  = accept;

    // A response in the flush cycle belongs to the old stream as well.
    rsp_drop       = imem_rsp_valid && (flush || (drop_cnt_q != '0));
    rsp_keep       = imem_rsp_valid && !rsp_drop;

    inst_valid     = !queue_empty;
    inst_pop       = inst_valid && inst_ready;
    inst_data      = inst_valid ? queue_head.data : '0;
    inst_pc        = inst_valid ? queue_head.addr : RST_PC_ADDRESS;

    queue_push_entry = '{data: imem_rsp_data, addr: addr_head};
  end

  always_comb begin
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    pending       = '0;

    if (flush) begin
      // Everything memory still owes becomes garbage; a flush during an
      // earlier drain keeps the responses already being swallowed.
      pending = SW'(drop_cnt_q) + SW'(outstanding_q);
      if (imem_rsp_valid && (pending != '0)) begin
        pending = pending - SW'(1);
      end
      drop_cnt_d    = CW'(pending);
      outstanding_d = '0;
    end else begin
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_keep);
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  ifetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head_data (addr_head),
    .count     (addr_count),
    .empty     (addr_empty),
    .full      (addr_full)
  );

  ifetch_fifo #(
    .WIDTH ($bits(inst_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (rsp_keep),
    .push_data (queue_push_entry),
    .pop       (inst_pop),
    .head_data (queue_head),
    .count     (queue_count),
    .empty     (queue_empty),
    .full      (queue_full)
  );

  a_queue_never_overflows: assert property (
    @(posedge clk) disable iff (!rst_n) !(rsp_keep && queue_full && !inst_pop)
  );

  a_rsp_has_address: assert property (
    @(posedge clk) disable iff (!rst_n) !(rsp_keep && addr_empty)
  );

  a_addr_fifo_never_overflows: assert property (
    @(posedge clk) disable iff (!rst_n) !(accept && addr_full && !rsp_keep)
  );

  a_addr_fifo_tracks_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) (addr_count == outstanding_q)
  );

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch
//   Directed bench for ifetch (DEPTH=2). A queue-based memory model answers
//   accepted requests in order with data = ~addr, one cycle after acceptance
//   unless mem_hold stalls it. The bench plays the pc stage: fetch_pc steps by
//   4 after every cycle in which fetch_advance was high.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        fetch_advance;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  ifetch #(
    .DEPTH          (2),
    .RST_PC_ADDRESS (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_pc       (fetch_pc),
    .flush          (flush),
    .fetch_advance  (fetch_advance),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: accepted address enters first, so a request can be
  // answered in the very next cycle (latency 1).
  logic [31:0] mem_fifo [$];
  logic        mem_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_fifo.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) mem_fifo.push_back(imem_req_addr);
      if (!mem_hold && (mem_fifo.size() > 0)) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= ~mem_fifo.pop_front();
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;
  int          cyc;
  int          n_acc;
  logic [31:0] pc_stop;
  logic        advlog [16];
  logic [31:0] dv_pc   [$];
  logic [31:0] dv_data [$];
  int          dv_cyc  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dvp(input int i);
    if (i < dv_pc.size()) return dv_pc[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] dvd(input int i);
    if (i < dv_data.size()) return dv_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] dvc(input int i);
    if (i < dv_cyc.size()) return 32'(dv_cyc[i]);
    return 32'hxxxx_xxxx;
  endfunction

  // One clock cycle: sample just before the edge, then act as the pc stage.
  task automatic cycle();
    logic adv;
    #1;
    if (inst_valid && inst_ready) begin
      dv_pc.push_back(inst_pc);
      dv_data.push_back(inst_data);
      dv_cyc.push_back(cyc);
    end
    adv = fetch_advance;
    if (cyc < 16) advlog[cyc] = adv;
    if (adv) n_acc++;
    @(posedge clk);
    #2;
    if (adv) fetch_pc = fetch_pc + 32'd4;
    if (fetch_pc == pc_stop) imem_req_ready = 1'b0;
    cyc++;
  endtask

  task automatic clear_log();
    dv_pc.delete();
    dv_data.delete();
    dv_cyc.delete();
    cyc   = 0;
    n_acc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e_adv;

    rst_n          = 1'b0;
    flush          = 1'b0;
    fetch_pc       = 32'h0000_0abc;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    mem_hold       = 1'b0;
    pc_stop        = 32'hffff_ffff;
    clear_log();

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, RST_PC);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0abc);

    // Streaming with latency-1 memory and decode always ready
    rst_n          = 1'b1;
    fetch_pc       = 32'h0;
    inst_ready     = 1'b1;
    pc_stop        = 32'h0000_000c;
    clear_log();
    repeat (8) cycle();
    chk("a_adv0", 32'(advlog[0]), 32'd1);
    chk("a_adv1", 32'(advlog[1]), 32'd1);
    chk("a_adv2_credit", 32'(advlog[2]), 32'd0);
    chk("a_adv3", 32'(advlog[3]), 32'd1);
    chk("a_count", 32'(dv_pc.size()), 32'd3);
    chk("a_pc0", dvp(0), 32'h0);
    chk("a_pc1", dvp(1), 32'h4);
    chk("a_pc2", dvp(2), 32'h8);
    chk("a_data0", dvd(0), ~32'h0);
    chk("a_data2", dvd(2), ~32'h8);
    chk("a_first_cycle", dvc(0), 32'd2);
    chk("a_second_cycle", dvc(1), 32'd3);
    chk("a_third_cycle", dvc(2), 32'd5);

    // Decode stalled: credit limit caps requests at two
    clear_log();
    fetch_pc       = 32'h0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    pc_stop        = 32'hffff_ffff;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i >= 2) chk("b_hold_pc", inst_pc, 32'h0);
      cycle();
    end
    chk("b_accepts", 32'(n_acc), 32'd2);
    #1;
    chk("b_adv_off", 32'(fetch_advance), 32'd0);
    chk("b_req_valid_off", 32'(imem_req_valid), 32'd0);
    chk("b_hold_data", inst_data, ~32'h0);
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    cycle();
    #1;
    chk("b_drain_pc1", inst_pc, 32'h4);
    cycle();
    #1;
    chk("b_drain_empty", 32'(inst_valid), 32'd0);

    // Flush with two outstanding requests
    clear_log();
    mem_hold       = 1'b1;
    fetch_pc       = 32'h10;
    imem_req_ready = 1'b1;
    pc_stop        = 32'h18;
    cycle();
    cycle();
    flush          = 1'b1;
    fetch_pc       = 32'h100;
    imem_req_ready = 1'b1;
    pc_stop        = 32'h104;
    #1;
    chk("c_flush_req_valid", 32'(imem_req_valid), 32'd0);
    chk("c_flush_adv", 32'(fetch_advance), 32'd0);
    cycle();
    flush    = 1'b0;
    mem_hold = 1'b0;
    #1;
    chk("c_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    chk("c_drop_credit", 32'(imem_req_valid), 32'd0);
    repeat (8) cycle();
    chk("c_count", 32'(dv_pc.size()), 32'd1);
    chk("c_pc0", dvp(0), 32'h100);
    chk("c_data0", dvd(0), ~32'h100);

    // Flush in the same cycle as the response for 0x10
    clear_log();
    mem_hold       = 1'b1;
    fetch_pc       = 32'h10;
    imem_req_ready = 1'b1;
    pc_stop        = 32'h18;
    cycle();
    cycle();
    mem_hold = 1'b0;
    cycle();
    flush          = 1'b1;
    fetch_pc       = 32'h200;
    imem_req_ready = 1'b1;
    pc_stop        = 32'h204;
    cycle();
    flush = 1'b0;
    #1;
    chk("d_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    repeat (6) cycle();
    chk("d_count", 32'(dv_pc.size()), 32'd1);
    chk("d_pc0", dvp(0), 32'h200);
    chk("d_data0", dvd(0), ~32'h200);

    // Request ready toggling 1010...
    clear_log();
    fetch_pc   = 32'h300;
    pc_stop    = 32'hffff_ffff;
    inst_ready = 1'b1;
    e_adv      = 8'b0101_0101;
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = ((i % 2) == 0);
      #1;
      chk("e_adv", 32'(fetch_advance), 32'(e_adv[i]));
      cycle();
    end
    imem_req_ready = 1'b0;
    repeat (4) cycle();
    chk("e_count", 32'(dv_pc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("e_pc", dvp(k), 32'h300 + 32'(4 * k));
    end

    // Reset while one instruction is queued and one request is outstanding
    clear_log();
    inst_ready     = 1'b0;
    mem_hold       = 1'b0;
    fetch_pc       = 32'h400;
    imem_req_ready = 1'b1;
    pc_stop        = 32'h408;
    cycle();
    mem_hold = 1'b1;
    cycle();
    #1;
    chk("f_pre_valid", 32'(inst_valid), 32'd1);
    chk("f_pre_pc", inst_pc, 32'h400);
    rst_n = 1'b0;
    #1;
    chk("f_rst_valid", 32'(inst_valid), 32'd0);
    chk("f_rst_pc", inst_pc, RST_PC);
    chk("f_rst_data", inst_data, 32'd0);
    chk("f_rst_req_valid", 32'(imem_req_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n          = 1'b1;
    mem_hold       = 1'b0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b0;
    repeat (4) cycle();
    chk("f_no_stale", 32'(dv_pc.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
